arqui_stim_gen: RTL

//  Stimulus-side counterpart to the output comparator of the arquitectura bench.

---
 rtl/arqui_stim_gen_if.sv | 48 ++++
 rtl/arqui_stim_gen.sv | 137 +++++++++++++
 2 files changed

// File: rtl/arqui_stim_gen_if.sv
// -----------------------------------------------------------------------------
// arqui_stim_gen_if
//   Bundles the stimulus generator's bench-facing signals: the run control
//   (start/done/timeout/sent_cnt), the two push channels toward the DUT input
//   FIFOs, and the pop strobes plus empty flags for the DUT output FIFOs.
//
//   master : the stimulus generator (drives push/data/pop/status)
//   slave  : the bench or DUT side (drives start, pause, empty flags)
//
//   start      run request
//   pause      DUT backpressure, 1 = stop pushing
//   empty_0/1  DUT output FIFO empty flags
//   push_0/1   push strobes, channel 0/1
//   data_out0/1  word for channel 0/1, valid with its push strobe
//   pop_0/1    pop strobes, output FIFO 0/1
//   sent_cnt   words pushed in the current run
//   done       run complete, held until the next start
//   timeout    drain ended by timeout, sticky until start or reset
// -----------------------------------------------------------------------------
interface arqui_stim_gen_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  start;
    logic                  pause;
    logic                  empty_0;
    logic                  empty_1;
    logic                  push_0;
    logic                  push_1;
    logic [DATA_WIDTH-1:0] data_out0;
    logic [DATA_WIDTH-1:0] data_out1;
    logic                  pop_0;
    logic                  pop_1;
    logic [7:0]            sent_cnt;
    logic                  done;
    logic                  timeout;

    modport master (
        input  start, pause, empty_0, empty_1,
        output push_0, push_1, data_out0, data_out1,
        output pop_0, pop_1, sent_cnt, done, timeout
    );

    modport slave (
        output start, pause, empty_0, empty_1,
        input  push_0, push_1, data_out0, data_out1,
        input  pop_0, pop_1, sent_cnt, done, timeout
    );
endinterface

// File: rtl/arqui_stim_gen.sv
// -----------------------------------------------------------------------------
// arqui_stim_gen
//   Stimulus generator for the arquitectura bench. Pushes NUM_WORDS words from
//   an 8-bit Fibonacci LFSR alternately into DUT input channels 0 and 1,
//   honouring the DUT pause flag, then drains both DUT output FIFOs with pop
//   strobes until they stay empty (or DRAIN_TIMEOUT expires) and raises done.
//
//   clk      rising-edge clock
//   reset_L  synchronous reset, active-low
//   bus      arqui_stim_gen_if.master (see interface header for signal list)
//
//   Every output is a register; pops therefore reflect the empty flags seen
//   at the previous edge.
// -----------------------------------------------------------------------------
module arqui_stim_gen #(
    parameter int          DATA_WIDTH    = 4,
    parameter int          NUM_WORDS     = 16,
    parameter logic [7:0]  SEED          = 8'hB5,
    parameter int          DRAIN_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_L,
    arqui_stim_gen_if.master bus
);

    // An all-zero seed would lock the LFSR at zero.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] LAST_CNT = 8'(NUM_WORDS - 1);
    localparam int         DCW      = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND  = 3'd1,
        HOLD  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t         state;
    logic [7:0]     lfsr;
    logic [DCW-1:0] drain_cnt;
    logic           both_empty_q;  // both FIFOs were empty at the previous DRAIN edge
    logic           both_empty;

    assign both_empty = bus.empty_0 & bus.empty_1;

    // Taps x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    // NOTE: all state lives in this one clocked block and is written with <=,
    // so every branch sees the pre-edge values of sent_cnt, lfsr and drain_cnt.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state         <= IDLE;
            lfsr          <= SEED_EFF;
            drain_cnt     <= '0;
            both_empty_q  <= 1'b0;
            bus.push_0    <= 1'b0;
            bus.push_1    <= 1'b0;
            bus.data_out0 <= '0;
            bus.data_out1 <= '0;
            bus.pop_0     <= 1'b0;
            bus.pop_1     <= 1'b0;
            bus.sent_cnt  <= 8'd0;
            bus.done      <= 1'b0;
            bus.timeout   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            bus.push_0 <= 1'b0;
            bus.push_1 <= 1'b0;
            bus.pop_0  <= 1'b0;
            bus.pop_1  <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state        <= SEND;
                        bus.sent_cnt <= 8'd0;
                        bus.timeout  <= 1'b0;
                        bus.done     <= 1'b0;
                        lfsr         <= SEED_EFF;
                    end
                end

                // HOLD differs from SEND only in that it was entered by pause;
                // a low pause in either state emits the next word on this edge.
                SEND, HOLD: begin
                    if (bus.pause) begin
                        state <= HOLD;
                    end else begin
                        // NOTE: the idle channel's data bus is deliberately not
                        // assigned, so it keeps its last word.
                        if (!bus.sent_cnt[0]) begin
                            bus.push_0    <= 1'b1;
                            bus.data_out0 <= lfsr[DATA_WIDTH-1:0];
                        end else begin
                            bus.push_1    <= 1'b1;
                            bus.data_out1 <= lfsr[DATA_WIDTH-1:0];
                        end
                        lfsr         <= lfsr_next(lfsr);
                        bus.sent_cnt <= bus.sent_cnt + 8'd1;
                        if (bus.sent_cnt == LAST_CNT) begin
                            state        <= DRAIN;
                            drain_cnt    <= '0;
                            both_empty_q <= 1'b0;
                        end else begin
                            state <= SEND;
                        end
                    end
                end

                DRAIN: begin
                    drain_cnt    <= drain_cnt + 1'b1;
                    both_empty_q <= both_empty;
                    // Normal exit is checked first so it wins a tie with timeout.
                    if (both_empty && both_empty_q) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state       <= DONE;
                        bus.done    <= 1'b1;
                        bus.timeout <= 1'b1;
                    end else begin
                        bus.pop_0 <= ~bus.empty_0;
                        bus.pop_1 <= ~bus.empty_1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
